iir_decim_avg: RTL and testbench

- Downstream stage of the scalar IIR filter. Consumes the filter's data_out and saturation outputs, one sample per cycle while enable is high.
- Averages each block of 2^decim_log2 consecutive samples and emits one decimated sample per block.
- Results go through a 2-entry output FIFO with a valid/ready handshake.
- Flags blocks that contained a saturated sample, and counts blocks dropped because of output back-pressure.

---
 rtl/iir_decim_avg.sv | 103 ++++++++++
 tb/tb_iir_decim_avg.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/iir_decim_avg.sv
// iir_decim_avg: block-average decimator with a 2-entry valid/ready output FIFO
module iir_decim_avg #(
  parameter int data_width = 6,
  parameter int decim_log2 = 2,
  parameter int round_mode = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  init_n,
  input  logic                  enable,
  input  logic [data_width-1:0] data_in,
  input  logic                  sat_in,
  input  logic                  dout_ready,
  output logic                  dout_valid,
  output logic [data_width-1:0] dout,
  output logic                  dout_sat,
  output logic                  overflow,
  output logic [7:0]            drop_cnt
);
  localparam int aw = data_width + decim_log2;
  localparam int n = 1 << decim_log2;
  localparam int rnd = (round_mode != 0 && decim_log2 > 0) ? n / 2 : 0;
  localparam logic [decim_log2:0] last = (decim_log2 + 1)'(n - 1);

  logic                         clr;
  logic signed [data_width-1:0] din;
  logic signed [aw-1:0]         acc;
  logic signed [aw-1:0]         sum;
  logic signed [aw-1:0]         rsum;
  logic [data_width-1:0]        res;
  logic [decim_log2:0]          cnt;
  logic                         sat_acc;
  logic                         blk_sat;
  logic                         done;
  logic                         pop;
  logic                         full;
  logic                         push_ok;
  logic                         drop;
  logic                         head_new;
  logic                         head_tail;
  logic                         tail_new;
  logic [1:0]                   fcnt;
  logic [data_width-1:0]        td;
  logic                         ts;

  assign clr = rst | ~init_n;
  assign din = data_in;
  assign sum = acc + aw'(din);
  assign rsum = sum + aw'(rnd);
  assign res = rsum[aw-1:decim_log2];
  assign blk_sat = sat_acc | sat_in;
  assign dout_valid = fcnt != 2'd0;

  // block completion and FIFO steering; dout is the head register so it holds when empty
  always_comb begin
    done = enable & (cnt == last);
    pop = dout_valid & dout_ready;
    full = fcnt == 2'd2;
    push_ok = done & (~full | pop);
    drop = done & full & ~pop;
    head_new = push_ok & ((fcnt == 2'd0) | ((fcnt == 2'd1) & pop));
    head_tail = pop & full;
    tail_new = push_ok & (full | ((fcnt == 2'd1) & ~pop));
  end

  // accumulator, FIFO registers and drop bookkeeping
  always_ff @(posedge clk) begin
    if (clr) begin
      acc <= '0;
      cnt <= '0;
      sat_acc <= 1'b0;
      dout <= '0;
      dout_sat <= 1'b0;
      td <= '0;
      ts <= 1'b0;
      fcnt <= '0;
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else begin
      if (enable) begin
        acc <= done ? '0 : sum;
        cnt <= done ? '0 : cnt + 1'b1;
        sat_acc <= done ? 1'b0 : blk_sat;
      end
      if (head_new) begin
        dout <= res;
        dout_sat <= blk_sat;
      end else if (head_tail) begin
        dout <= td;
        dout_sat <= ts;
      end
      if (tail_new) begin
        td <= res;
        ts <= blk_sat;
      end
      fcnt <= fcnt + {1'b0, push_ok} - {1'b0, pop};
      if (drop) begin
        overflow <= 1'b1;
        drop_cnt <= drop_cnt + {7'd0, drop_cnt != 8'hff};
      end
    end
  end
endmodule

// File: tb/tb_iir_decim_avg.sv
// tb_iir_decim_avg: scoreboard bench for round and floor variants driven in lockstep
module tb_iir_decim_avg;
  logic clk = 0, rst = 1, init_n = 1, enable = 0, sat_in = 0, dout_ready = 1;
  logic [5:0] data_in = '0;
  logic v1, s1, o1, v0, s0, o0;
  logic [5:0] d1, d0;
  logic [7:0] c1, c0;
  int total = 0, bad = 0;
  logic [6:0] q1[$];
  logic [6:0] q0[$];

  iir_decim_avg #(.data_width(6), .decim_log2(2), .round_mode(1)) dut1 (
    .clk(clk), .rst(rst), .init_n(init_n), .enable(enable), .data_in(data_in),
    .sat_in(sat_in), .dout_ready(dout_ready), .dout_valid(v1), .dout(d1),
    .dout_sat(s1), .overflow(o1), .drop_cnt(c1));

  iir_decim_avg #(.data_width(6), .decim_log2(2), .round_mode(0)) dut0 (
    .clk(clk), .rst(rst), .init_n(init_n), .enable(enable), .data_in(data_in),
    .sat_in(sat_in), .dout_ready(dout_ready), .dout_valid(v0), .dout(d0),
    .dout_sat(s0), .overflow(o0), .drop_cnt(c0));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic signed [31:0] act, input logic signed [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", nm, act, exp);
    end
  endtask

  // monitor: compare FIFO head against the scoreboard on every handshake
  always @(negedge clk) begin
    if (!rst && init_n) begin
      if (v1 && dout_ready) begin
        if (q1.size() == 0) begin
          total++; bad++;
          $display("FAIL round_unexpected got=%0d want=none", $signed(d1));
        end else begin
          logic [6:0] e;
          e = q1.pop_front();
          chk("round_dout", $signed(d1), $signed(e[5:0]));
          chk("round_sat", {31'd0, s1}, {31'd0, e[6]});
        end
      end
      if (v0 && dout_ready) begin
        if (q0.size() == 0) begin
          total++; bad++;
          $display("FAIL floor_unexpected got=%0d want=none", $signed(d0));
        end else begin
          logic [6:0] e;
          e = q0.pop_front();
          chk("floor_dout", $signed(d0), $signed(e[5:0]));
          chk("floor_sat", {31'd0, s0}, {31'd0, e[6]});
        end
      end
    end
  end

  task automatic blk(input logic signed [5:0] x0, x1, x2, x3, input logic [3:0] sm,
                     input logic signed [5:0] er, ef, input logic es, input bit keep, input bit rl);
    logic signed [5:0] x[4];
    x = '{x0, x1, x2, x3};
    for (int i = 0; i < 4; i++) begin
      enable = 1;
      data_in = x[i];
      sat_in = sm[i];
      if (i == 3 && rl) dout_ready = 1;
      if (i == 3 && keep) begin
        q1.push_back({es, er});
        q0.push_back({es, ef});
      end
      @(posedge clk); #1;
    end
    enable = 0;
    sat_in = 0;
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && (q1.size() + q0.size()) != 0; i++) @(posedge clk);
    #1;
    chk("drain_left", q1.size() + q0.size(), 0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 0;
    chk("rst_valid", {31'd0, v1}, 0);
    chk("rst_dout", $signed(d1), 0);
    chk("rst_sat", {31'd0, s1}, 0);
    chk("rst_ovf", {31'd0, o1}, 0);
    chk("rst_drop", {24'd0, c1}, 0);
    chk("rst_valid0", {31'd0, v0}, 0);
    blk(1, 2, 3, 4, 4'b0000, 3, 2, 0, 1, 0);
    @(negedge clk);
    chk("latency_valid", {31'd0, v1}, 1);
    drain();
    blk(-32, -32, -32, -32, 4'b0000, -32, -32, 0, 1, 0);
    blk(31, 31, 31, 31, 4'b0000, 31, 31, 0, 1, 0);
    blk(-1, -2, -1, -1, 4'b0000, -1, -2, 0, 1, 0);
    blk(2, 2, 2, 2, 4'b0010, 2, 2, 1, 1, 0);
    blk(3, 3, 3, 3, 4'b0000, 3, 3, 0, 1, 0);
    drain();
    chk("no_ovf", {31'd0, o1}, 0);
    dout_ready = 0;
    blk(4, 4, 4, 4, 4'b0000, 4, 4, 0, 1, 0);
    blk(-4, -4, -4, -4, 4'b0000, -4, -4, 0, 1, 0);
    blk(7, 7, 7, 7, 4'b0000, 7, 7, 0, 0, 0);
    chk("bp_ovf", {31'd0, o1}, 1);
    chk("bp_drop", {24'd0, c1}, 1);
    chk("bp_ovf0", {31'd0, o0}, 1);
    chk("bp_drop0", {24'd0, c0}, 1);
    chk("bp_valid", {31'd0, v1}, 1);
    chk("bp_head", $signed(d1), 4);
    dout_ready = 1;
    drain();
    dout_ready = 0;
    blk(1, 1, 1, 1, 4'b0000, 1, 1, 0, 1, 0);
    blk(2, 2, 2, 2, 4'b0000, 2, 2, 0, 1, 0);
    blk(5, 5, 5, 6, 4'b0000, 5, 5, 0, 1, 1);
    chk("full_pop_valid", {31'd0, v1}, 1);
    drain();
    chk("full_pop_drop", {24'd0, c1}, 1);
    enable = 1; data_in = 9; sat_in = 1;
    repeat (2) @(posedge clk);
    #1 enable = 0; sat_in = 0; init_n = 0;
    @(posedge clk); #1 init_n = 1;
    chk("init_ovf", {31'd0, o1}, 0);
    blk(5, 5, 5, 5, 4'b0000, 5, 5, 0, 1, 0);
    drain();
    dout_ready = 0;
    blk(6, 6, 6, 6, 4'b0001, 6, 6, 1, 0, 0);
    blk(7, 7, 7, 7, 4'b0000, 7, 7, 0, 0, 0);
    blk(8, 8, 8, 8, 4'b0000, 8, 8, 0, 0, 0);
    chk("pre_rst_valid", {31'd0, v1}, 1);
    chk("pre_rst_sat", {31'd0, s1}, 1);
    chk("pre_rst_ovf", {31'd0, o1}, 1);
    rst = 1;
    @(posedge clk); #1 rst = 0;
    chk("post_rst_valid", {31'd0, v1}, 0);
    chk("post_rst_dout", $signed(d1), 0);
    chk("post_rst_sat", {31'd0, s1}, 0);
    chk("post_rst_ovf", {31'd0, o1}, 0);
    chk("post_rst_drop", {24'd0, c1}, 0);
    chk("post_rst_valid0", {31'd0, v0}, 0);
    dout_ready = 1;
    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
